// File: rtl/addr_ft_pkg.sv
// Shared types and elaboration helpers for the sequential fault-resilient adder.
package addr_ft_pkg;

  typedef enum logic [1:0] {IDLE, COMPUTE, CHECK, DONE} addr_ft_state_t;

  // Width of one carry chunk processed per COMPUTE cycle.
  function automatic int chunk_w(input int width, input int stages);
    return width / stages;
  endfunction

  // Legal configuration: chunks tile the operand exactly, retry count fits 2 bits.
  function automatic bit cfg_ok(input int width, input int stages, input int retry_max);
    return (stages > 0) && (width > 0) && ((width % stages) == 0) &&
           (retry_max >= 0) && (retry_max <= 3);
  endfunction

endpackage

// File: rtl/residue_mod3.sv
// Combinational mod-3 residue. Since 4 == 1 (mod 3), each 2-bit digit contributes
// its own value, so the residue is the running mod-3 sum of the 2-bit pairs.
module residue_mod3 #(
  parameter int W = 8
) (
  input  logic [W-1:0] val_i,
  output logic [1:0]   res_o
);
  localparam int NP = (W + 1) / 2;

  logic [2*NP-1:0] padded;
  logic [2:0]      t;
  logic [1:0]      acc;

  // Fold 2-bit digits into a residue accumulator kept in 0..2.
  always_comb begin
    padded        = '0;
    padded[W-1:0] = val_i;
    acc           = '0;
    t             = '0;
    for (int i = 0; i < NP; i++) begin
      t   = {1'b0, acc} + {1'b0, padded[2*i +: 2]};
      acc = (t >= 3'd3) ? 2'(t - 3'd3) : t[1:0];
    end
    res_o = acc;
  end

endmodule

// File: rtl/addr_ft_seq.sv
// Sequential chunked adder with mod-3 residue check and bounded retry.
// Optional fault injection ports are compiled in with ADDR_FT_FAULT_INJECT_EN.
module addr_ft_seq
  import addr_ft_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int STAGES    = 2,
  parameter int RETRY_MAX = 1,
  parameter int CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   sum,
  output logic             out_err,
  output logic             fault_sticky,
  output logic [CNT_W-1:0] fault_cnt
`ifdef ADDR_FT_FAULT_INJECT_EN
  ,
  input  logic                         inj_en,
  input  logic [$clog2(WIDTH+1)-1:0]   inj_bit
`endif
);

  localparam int             CW   = chunk_w(WIDTH, STAGES);
  localparam int             KW   = (STAGES > 1) ? $clog2(STAGES) : 1;
  localparam logic [KW-1:0]  LAST = KW'(STAGES - 1);
  localparam logic [1:0]     RMAX = 2'(RETRY_MAX);

  if (!cfg_ok(WIDTH, STAGES, RETRY_MAX)) begin : g_bad_cfg
    $error("addr_ft_seq: WIDTH must be divisible by STAGES and RETRY_MAX must be 0..3");
  end

  addr_ft_state_t   state_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic             carry_q;
  logic [KW-1:0]    k_q;
  logic [1:0]       r_q;
  logic [WIDTH:0]   sum_q, sum_d;
  logic             err_q;
  logic             sticky_q;
  logic [CNT_W-1:0] cnt_q;

  logic [CW-1:0]    a_chunk, b_chunk, chunk_s;
  logic             chunk_c;
  logic [WIDTH:0]   inj_mask;
  logic [1:0]       res_a, res_b, res_s, res_exp;
  logic [2:0]       res_t;
  logic             mismatch;
  logic             accept;

  assign accept = in_valid && (state_q == IDLE);

`ifdef ADDR_FT_FAULT_INJECT_EN
  logic [WIDTH:0] inj_mask_q;

  // Injection mask is armed at accept and disarmed at the first CHECK, so retries are clean.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inj_mask_q <= '0;
    end else if (accept) begin
      inj_mask_q <= inj_en ? ({{WIDTH{1'b0}}, 1'b1} << inj_bit) : '0;
    end else if (state_q == CHECK) begin
      inj_mask_q <= '0;
    end
  end

  assign inj_mask = inj_mask_q;
`else
  assign inj_mask = '0;
`endif

  residue_mod3 #(.W(WIDTH))   u_res_a (.val_i(a_q),   .res_o(res_a));
  residue_mod3 #(.W(WIDTH))   u_res_b (.val_i(b_q),   .res_o(res_b));
  residue_mod3 #(.W(WIDTH+1)) u_res_s (.val_i(sum_q), .res_o(res_s));

  // Expected residue of the sum is the mod-3 sum of operand residues.
  always_comb begin
    res_t    = {1'b0, res_a} + {1'b0, res_b};
    res_exp  = (res_t >= 3'd3) ? 2'(res_t - 3'd3) : res_t[1:0];
    mismatch = (res_exp != res_s);
  end

  // One chunk of the ripple: add the selected operand slices plus the carry,
  // write it into its slot, and place the final carry in the MSB.
  always_comb begin
    a_chunk = a_q[k_q*CW +: CW];
    b_chunk = b_q[k_q*CW +: CW];
    {chunk_c, chunk_s} = {1'b0, a_chunk} + {1'b0, b_chunk} + {{CW{1'b0}}, carry_q};
    sum_d = sum_q;
    sum_d[k_q*CW +: CW] = chunk_s ^ inj_mask[k_q*CW +: CW];
    if (k_q == LAST) sum_d[WIDTH] = chunk_c ^ inj_mask[WIDTH];
  end

  // Control FSM with all datapath and status registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      carry_q  <= 1'b0;
      k_q      <= '0;
      r_q      <= '0;
      sum_q    <= '0;
      err_q    <= 1'b0;
      sticky_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            a_q     <= a;
            b_q     <= b;
            carry_q <= 1'b0;
            k_q     <= '0;
            r_q     <= '0;
            state_q <= COMPUTE;
          end
        end
        COMPUTE: begin
          sum_q   <= sum_d;
          carry_q <= chunk_c;
          if (k_q == LAST) state_q <= CHECK;
          else             k_q     <= k_q + KW'(1);
        end
        CHECK: begin
          if (!mismatch) begin
            err_q   <= 1'b0;
            state_q <= DONE;
          end else begin
            sticky_q <= 1'b1;
            if (cnt_q != {CNT_W{1'b1}}) cnt_q <= cnt_q + CNT_W'(1);
            if (r_q < RMAX) begin
              // Recompute from the latched operands.
              r_q     <= r_q + 2'd1;
              k_q     <= '0;
              carry_q <= 1'b0;
              state_q <= COMPUTE;
            end else begin
              err_q   <= 1'b1;
              state_q <= DONE;
            end
          end
        end
        DONE: begin
          if (out_ready) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready     = (state_q == IDLE);
  assign out_valid    = (state_q == DONE);
  assign sum          = sum_q;
  assign out_err      = err_q;
  assign fault_sticky = sticky_q;
  assign fault_cnt    = cnt_q;

endmodule

// File: tb/tb_addr_ft_seq.sv
// Directed bench for addr_ft_seq (WIDTH=8, STAGES=2, RETRY_MAX=1).
// Inputs are driven 1ns after a rising edge and outputs sampled there too.
module tb_addr_ft_seq;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] a, b;
  logic       out_valid;
  logic       out_ready;
  logic [8:0] sum;
  logic       out_err;
  logic       fault_sticky;
  logic [7:0] fault_cnt;
`ifdef ADDR_FT_FAULT_INJECT_EN
  logic       inj_en;
  logic [3:0] inj_bit;
`endif

  int n_pass = 0;
  int n_tot  = 0;

  always #5 clk = ~clk;

  addr_ft_seq #(.WIDTH(8), .STAGES(2), .RETRY_MAX(1), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .out_err(out_err),
    .fault_sticky(fault_sticky), .fault_cnt(fault_cnt)
`ifdef ADDR_FT_FAULT_INJECT_EN
    , .inj_en(inj_en), .inj_bit(inj_bit)
`endif
  );

  task automatic step();
    @(posedge clk); #1;
  endtask

  // Present operands for one accepting edge, then count edges until out_valid (bounded).
  task automatic do_op(input logic [7:0] av, input logic [7:0] bv, output int lat);
    in_valid = 1'b1; a = av; b = bv;
    step();
    in_valid = 1'b0;
    lat = 0;
    for (int i = 0; i < 40; i++) begin
      if (out_valid) break;
      step();
      lat++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0;
`ifdef ADDR_FT_FAULT_INJECT_EN
    inj_en = 1'b0; inj_bit = '0;
`endif
    #12;
    n_tot++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got %b want 1", in_ready); else n_pass++;
    n_tot++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b want 0", out_valid); else n_pass++;
    n_tot++; if (sum !== 9'h000) $display("FAIL reset_sum got %h want 000", sum); else n_pass++;
    n_tot++; if ({out_err, fault_sticky} !== 2'b00) $display("FAIL reset_err_sticky got %b want 00", {out_err, fault_sticky}); else n_pass++;
    n_tot++; if (fault_cnt !== 8'h00) $display("FAIL reset_fault_cnt got %h want 00", fault_cnt); else n_pass++;
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_basic();
    int lat;
    do_op(8'd200, 8'd100, lat);
    n_tot++; if (lat !== 3) $display("FAIL basic_latency got %0d want 3", lat); else n_pass++;
    n_tot++; if (sum !== 9'h12C) $display("FAIL basic_sum got %h want 12c", sum); else n_pass++;
    n_tot++; if (out_err !== 1'b0) $display("FAIL basic_err got %b want 0", out_err); else n_pass++;
    n_tot++; if (fault_cnt !== 8'h00) $display("FAIL basic_cnt got %h want 00", fault_cnt); else n_pass++;
    step();
    n_tot++; if ({out_valid, in_ready} !== 2'b01) $display("FAIL basic_release got %b want 01", {out_valid, in_ready}); else n_pass++;
  endtask

  task automatic test_carry_edges();
    int lat;
    do_op(8'd255, 8'd255, lat);
    n_tot++; if (sum !== 9'h1FE) $display("FAIL max_sum got %h want 1fe", sum); else n_pass++;
    n_tot++; if (lat !== 3) $display("FAIL max_latency got %0d want 3", lat); else n_pass++;
    step();
    do_op(8'd0, 8'd0, lat);
    n_tot++; if (sum !== 9'h000) $display("FAIL zero_sum got %h want 000", sum); else n_pass++;
    step();
    // carry generated in the low chunk only
    do_op(8'h0F, 8'h01, lat);
    n_tot++; if (sum !== 9'h010) $display("FAIL chunk_carry_sum got %h want 010", sum); else n_pass++;
    step();
  endtask

  task automatic test_backpressure();
    int lat;
    out_ready = 1'b0;
    do_op(8'd10, 8'd20, lat);
    n_tot++; if (lat !== 3) $display("FAIL bp_latency got %0d want 3", lat); else n_pass++;
    in_valid = 1'b1; a = 8'd99; b = 8'd99;
    for (int i = 0; i < 5; i++) begin
      step();
      n_tot++;
      if ({out_valid, in_ready, out_err, sum} !== {1'b1, 1'b0, 1'b0, 9'd30})
        $display("FAIL bp_hold cycle %0d got v=%b r=%b e=%b s=%h want v=1 r=0 e=0 s=01e",
                 i, out_valid, in_ready, out_err, sum);
      else n_pass++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    step();
    n_tot++; if ({out_valid, in_ready} !== 2'b01) $display("FAIL bp_release got %b want 01", {out_valid, in_ready}); else n_pass++;
    step(); step(); step(); step();
    n_tot++; if ({out_valid, sum} !== {1'b0, 9'd30}) $display("FAIL bp_ignored got v=%b s=%h want v=0 s=01e", out_valid, sum); else n_pass++;
  endtask

`ifdef ADDR_FT_FAULT_INJECT_EN
  task automatic test_inject();
    int lat;
    inj_en = 1'b1; inj_bit = 4'd3;
    in_valid = 1'b1; a = 8'h0F; b = 8'h01;
    step();
    inj_en = 1'b0; inj_bit = '0; in_valid = 1'b0;
    step(); step();
    n_tot++; if (sum !== 9'h018) $display("FAIL inj_first_pass got %h want 018", sum); else n_pass++;
    lat = 2;
    for (int i = 0; i < 40; i++) begin
      if (out_valid) break;
      step();
      lat++;
    end
    n_tot++; if (lat !== 6) $display("FAIL inj_latency got %0d want 6", lat); else n_pass++;
    n_tot++; if (sum !== 9'h010) $display("FAIL inj_sum got %h want 010", sum); else n_pass++;
    n_tot++; if ({out_err, fault_sticky} !== 2'b01) $display("FAIL inj_err_sticky got %b want 01", {out_err, fault_sticky}); else n_pass++;
    n_tot++; if (fault_cnt !== 8'h01) $display("FAIL inj_cnt got %h want 01", fault_cnt); else n_pass++;
    step();
  endtask
`endif

  task automatic test_reset_mid_op();
    int lat;
    in_valid = 1'b1; a = 8'd5; b = 8'd6;
    step();
    in_valid = 1'b0;
    step();
    #2 rst_n = 1'b0;
    #1;
    n_tot++; if ({out_valid, in_ready} !== 2'b01) $display("FAIL rst_mid_handshake got %b want 01", {out_valid, in_ready}); else n_pass++;
    n_tot++; if ({sum, out_err, fault_sticky, fault_cnt} !== 19'h0)
      $display("FAIL rst_mid_outputs got s=%h e=%b st=%b c=%h want all 0", sum, out_err, fault_sticky, fault_cnt); else n_pass++;
    step(); step();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) step();
    n_tot++; if ({out_valid, in_ready, fault_cnt} !== {1'b0, 1'b1, 8'h00})
      $display("FAIL rst_mid_after got v=%b r=%b c=%h want v=0 r=1 c=00", out_valid, in_ready, fault_cnt); else n_pass++;
    do_op(8'd5, 8'd6, lat);
    n_tot++; if ({lat[3:0], sum, out_err} !== {4'd3, 9'd11, 1'b0})
      $display("FAIL rst_mid_next got lat=%0d s=%h e=%b want lat=3 s=00b e=0", lat, sum, out_err); else n_pass++;
    step();
  endtask

  // Pin the sum register to zero so every residue check fails on both passes.
  task automatic test_persistent_fault();
    int lat;
    force dut.sum_q = 9'h000;
    do_op(8'd1, 8'd0, lat);
    n_tot++; if (lat !== 6) $display("FAIL persist_latency got %0d want 6", lat); else n_pass++;
    n_tot++; if ({out_err, fault_sticky} !== 2'b11) $display("FAIL persist_err_sticky got %b want 11", {out_err, fault_sticky}); else n_pass++;
    n_tot++; if (fault_cnt !== 8'h02) $display("FAIL persist_cnt got %h want 02", fault_cnt); else n_pass++;
    step();
    for (int i = 1; i <= 150; i++) begin
      do_op(8'd1, 8'd0, lat);
      if (i == 126) begin
        n_tot++; if (fault_cnt !== 8'hFE) $display("FAIL sat_pre got %h want fe", fault_cnt); else n_pass++;
      end
      if (i == 127) begin
        n_tot++; if (fault_cnt !== 8'hFF) $display("FAIL sat_hit got %h want ff", fault_cnt); else n_pass++;
      end
      step();
    end
    n_tot++; if (fault_cnt !== 8'hFF) $display("FAIL sat_hold got %h want ff", fault_cnt); else n_pass++;
    release dut.sum_q;
    do_op(8'd3, 8'd4, lat);
    n_tot++; if ({sum, out_err, fault_sticky, fault_cnt} !== {9'd7, 1'b0, 1'b1, 8'hFF})
      $display("FAIL post_release got s=%h e=%b st=%b c=%h want s=007 e=0 st=1 c=ff",
               sum, out_err, fault_sticky, fault_cnt); else n_pass++;
    step();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_carry_edges();
    test_backpressure();
`ifdef ADDR_FT_FAULT_INJECT_EN
    test_inject();
`endif
    test_reset_mid_op();
    test_persistent_fault();
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule

// File: doc/addr_ft_seq.md
Name: addr_ft_seq

Overview:
- Parametrised, sequential, fault-resilient unsigned adder. Successor to the fixed 8-bit combinational fault-resilient adders.
- Computes A+B over WIDTH bits in STAGES carry-chunk cycles.
- Checks every result with a mod-3 residue code and retries on mismatch.
- Sits behind a valid/ready handshake so datapath blocks can use it as a self-checking arithmetic unit.

Parameters:
- WIDTH, 8, operand width in bits; must be divisible by STAGES.
- STAGES, 2, carry-chunk cycles per computation; chunk width CW = WIDTH/STAGES.
- RETRY_MAX, 1, recomputations allowed after a residue mismatch (0..3).
- CNT_W, 8, width of the saturating fault event counter.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operands valid.
- in_ready  out  1  block can accept operands.
- a  in  WIDTH  operand A, unsigned.
- b  in  WIDTH  operand B, unsigned.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- sum  out  WIDTH+1  A+B; MSB is the carry-out.
- out_err  out  1  result failed the residue check on every attempt.
- fault_sticky  out  1  set on any mismatch; cleared only by reset.
- fault_cnt  out  CNT_W  count of mismatch events, saturating at all-ones.

Behaviour:
- Reset (async assert, sync deassert expected upstream):
  - State IDLE.
  - in_ready=1; out_valid=0; sum=0; out_err=0; fault_sticky=0; fault_cnt=0.
  - Internal operand, carry and retry registers are 0.
- States: IDLE, COMPUTE, CHECK, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: latch a and b, clear carry, set chunk index k=0 and retry counter r=0, go to COMPUTE.
- COMPUTE:
  - One cycle per chunk: sum[k*CW +: CW] = a_chunk + b_chunk + carry; carry register updated.
  - After chunk STAGES-1, the final carry goes to sum[WIDTH], then go to CHECK.
  - in_ready=0.
- CHECK (one cycle):
  - Compare (res3(a)+res3(b)) mod 3 against res3(sum).
  - Match: go to DONE with out_err=0.
  - Mismatch: set fault_sticky and increment fault_cnt (saturating).
    - If r<RETRY_MAX: r++, k=0, carry=0, go to COMPUTE, reusing the latched operands.
    - Else: go to DONE with out_err=1.
- DONE:
  - out_valid=1; sum and out_err held stable while out_ready=0.
  - On out_ready: out_valid=0, go to IDLE. in_ready rises the following cycle; no same-cycle turnaround.
- Latency, fault-free: out_valid asserts STAGES+1 cycles after the accepting edge. Each retry adds STAGES+1 cycles.
- Throughput: one operation in flight at a time.
- in_valid while busy is ignored; the upstream producer holds its data.
- Wrap-around: sum is full WIDTH+1 bits, so there is no overflow. 255+255 gives 9'h1FE.
- Any single-bit sum error changes res3 (2^i mod 3 ≠ 0) and is therefore always detected.
- Reset mid-operation: the operation is discarded, nothing is emitted, and all outputs go to reset values immediately.
- fault_cnt at all-ones stays all-ones.
- STAGES=1 is legal (single-cycle COMPUTE).

Optional Feature:
- Macro: ADDR_FT_FAULT_INJECT_EN.
- Defined: adds ports inj_en (in, 1) and inj_bit (in, $clog2(WIDTH+1)), both sampled at operand accept.
  - If inj_en is set, sum bit inj_bit is XOR-flipped when written during the first COMPUTE pass only.
  - Retries compute cleanly.
- Undefined: these ports and all injection logic are absent. Behaviour is otherwise identical.

Decomposition:
- Package addr_ft_pkg:
  - state enum type addr_ft_state_t {IDLE, COMPUTE, CHECK, DONE}.
  - localparam function for the CW derivation.
  - static elaboration check that WIDTH%STAGES==0 and RETRY_MAX≤3.
- Sub-module residue_mod3 (parameter W): combinational W-bit value to 2-bit residue via 2-bit-pair folding.
  - Instantiated three times: a, b, sum.

Test Plan (WIDTH=8, STAGES=2, RETRY_MAX=1):
- a=200, b=100, out_ready=1 -> out_valid 3 cycles after accept, sum=9'h12C, out_err=0, fault_cnt=0.
- a=255, b=255 -> sum=9'h1FE (carry ripples across the chunk boundary). a=0, b=0 -> sum=0.
- out_ready held 0 for 5 cycles after out_valid -> sum/out_err stable, in_ready=0, a new in_valid is ignored. Release -> in_ready=1 one cycle later.
- With ADDR_FT_FAULT_INJECT_EN: a=8'h0F, b=8'h01, inj_en=1, inj_bit=3.
  - First pass gives 9'h018; mismatch detected.
  - Retry yields sum=9'h010, out_err=0, fault_sticky=1, fault_cnt=1, latency 6 cycles.
- Force a persistent mismatch (bench force on one sum bit, both passes) -> out_err=1, fault_cnt=2.
  - Drive 300 further mismatches -> fault_cnt saturates at 8'hFF.
- Deassert rst_n during COMPUTE -> out_valid stays 0, in_ready=1 and all counters 0 on release. The next operation completes normally.
